status_flags: RTL and testbench

STATUS_FLAGS -- requirements
Module: status_flags

---
 rtl/status_flags.sv | 160 ++++++++++++++++
 tb/tb_status_flags.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_flags.sv
// Processor status register with ALU/BIT/PLP/flag-op updates, branch
// condition decode and IRQ/NMI request generation.
module status_flags #(
    parameter logic RESET_I = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ready,
    input  logic       alu_carry,
    input  logic       alu_overflow,
    input  logic       alu_zero,
    input  logic       alu_sign,
    input  logic       load_nz,
    input  logic       load_c,
    input  logic       load_v,
    input  logic       bit_op,
    input  logic       plp_load,
    input  logic [7:0] data_in,
    input  logic [2:0] flag_op,
    input  logic       brk_push,
    output logic [7:0] status_out,
    input  logic [2:0] branch_cond,
    output logic       branch_taken,
    input  logic       irq_n,
    input  logic       nmi_n,
    input  logic       intr_sample,
    input  logic       nmi_ack,
    output logic       irq_req,
    output logic       nmi_req
);

    localparam logic [2:0] OP_CLC = 3'd1;
    localparam logic [2:0] OP_SEC = 3'd2;
    localparam logic [2:0] OP_CLI = 3'd3;
    localparam logic [2:0] OP_SEI = 3'd4;
    localparam logic [2:0] OP_CLD = 3'd5;
    localparam logic [2:0] OP_SED = 3'd6;
    localparam logic [2:0] OP_CLV = 3'd7;

    logic n_reg, v_reg, d_reg, i_reg, z_reg, c_reg;
    logic n_next, v_next, d_next, i_next, z_next, c_next;
    logic i_mask_reg, i_mask_next;
    logic nmi_pending_reg, nmi_pending_next;
    logic nmi_prev_reg;
    logic nmi_edge;

    // Flag update: plp_load beats flag_op beats bit_op beats the ALU enables.
    always_comb begin
        n_next = n_reg;
        v_next = v_reg;
        d_next = d_reg;
        i_next = i_reg;
        z_next = z_reg;
        c_next = c_reg;
        if (ready) begin
            if (plp_load) begin
                // Bits 5 and 4 of the pulled byte are not stored.
                n_next = data_in[7];
                v_next = data_in[6];
                d_next = data_in[3];
                i_next = data_in[2];
                z_next = data_in[1];
                c_next = data_in[0];
            end else if (flag_op != 3'd0) begin
                case (flag_op)
                    OP_CLC:  c_next = 1'b0;
                    OP_SEC:  c_next = 1'b1;
                    OP_CLI:  i_next = 1'b0;
                    OP_SEI:  i_next = 1'b1;
                    OP_CLD:  d_next = 1'b0;
                    OP_SED:  d_next = 1'b1;
                    OP_CLV:  v_next = 1'b0;
                    default: ;
                endcase
            end else if (bit_op) begin
                n_next = data_in[7];
                v_next = data_in[6];
                z_next = alu_zero;
            end else begin
                if (load_nz) begin
                    n_next = alu_sign;
                    z_next = alu_zero;
                end
                if (load_c) begin
                    c_next = alu_carry;
                end
                if (load_v) begin
                    v_next = alu_overflow;
                end
            end
        end
    end

    // IRQ mask follows I only at instruction boundaries, so I changes act one instruction late.
    always_comb begin
        i_mask_next = i_mask_reg;
        if (ready && intr_sample) begin
            i_mask_next = i_reg;
        end
    end

    // NMI falling edge is captured even while stalled; a same-cycle edge wins over the ack.
    assign nmi_edge = nmi_prev_reg & ~nmi_n;

    always_comb begin
        nmi_pending_next = nmi_pending_reg;
        if (nmi_edge) begin
            nmi_pending_next = 1'b1;
        end else if (ready && nmi_ack) begin
            nmi_pending_next = 1'b0;
        end
    end

    // State register with synchronous reset overriding every update input.
    always_ff @(posedge clk) begin
        if (reset) begin
            n_reg           <= 1'b0;
            v_reg           <= 1'b0;
            d_reg           <= 1'b0;
            i_reg           <= RESET_I;
            z_reg           <= 1'b0;
            c_reg           <= 1'b0;
            i_mask_reg      <= RESET_I;
            nmi_pending_reg <= 1'b0;
            nmi_prev_reg    <= 1'b1;
        end else begin
            n_reg           <= n_next;
            v_reg           <= v_next;
            d_reg           <= d_next;
            i_reg           <= i_next;
            z_reg           <= z_next;
            c_reg           <= c_next;
            i_mask_reg      <= i_mask_next;
            nmi_pending_reg <= nmi_pending_next;
            nmi_prev_reg    <= nmi_n;
        end
    end

    assign status_out = {n_reg, v_reg, 1'b1, brk_push, d_reg, i_reg, z_reg, c_reg};

    // Branch condition decode from registered flags.
    always_comb begin
        branch_taken = 1'b0;
        case (branch_cond)
            3'd0:    branch_taken = ~n_reg;
            3'd1:    branch_taken = n_reg;
            3'd2:    branch_taken = ~v_reg;
            3'd3:    branch_taken = v_reg;
            3'd4:    branch_taken = ~c_reg;
            3'd5:    branch_taken = c_reg;
            3'd6:    branch_taken = ~z_reg;
            3'd7:    branch_taken = z_reg;
            default: branch_taken = 1'b0;
        endcase
    end

    assign irq_req = ~irq_n & ~i_mask_reg;
    assign nmi_req = nmi_pending_reg;

endmodule

// File: tb/tb_status_flags.sv
// Directed self-checking bench for status_flags.
module tb_status_flags;

    logic       clk = 1'b0;
    logic       reset, ready;
    logic       alu_carry, alu_overflow, alu_zero, alu_sign;
    logic       load_nz, load_c, load_v, bit_op, plp_load;
    logic [7:0] data_in;
    logic [2:0] flag_op;
    logic       brk_push;
    logic [7:0] status_out;
    logic [2:0] branch_cond;
    logic       branch_taken;
    logic       irq_n, nmi_n, intr_sample, nmi_ack;
    logic       irq_req, nmi_req;

    int total = 0;
    int bad   = 0;

    status_flags #(.RESET_I(1'b1)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .alu_carry(alu_carry), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_sign(alu_sign),
        .load_nz(load_nz), .load_c(load_c), .load_v(load_v),
        .bit_op(bit_op), .plp_load(plp_load), .data_in(data_in),
        .flag_op(flag_op), .brk_push(brk_push), .status_out(status_out),
        .branch_cond(branch_cond), .branch_taken(branch_taken),
        .irq_n(irq_n), .nmi_n(nmi_n), .intr_sample(intr_sample),
        .nmi_ack(nmi_ack), .irq_req(irq_req), .nmi_req(nmi_req)
    );

    always #5 clk = ~clk;

    // One clock edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; ready = 1;
        alu_carry = 0; alu_overflow = 0; alu_zero = 0; alu_sign = 0;
        load_nz = 0; load_c = 0; load_v = 0; bit_op = 0; plp_load = 0;
        data_in = 8'h00; flag_op = 3'd0; intr_sample = 0; nmi_ack = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        irq_n = 1; nmi_n = 1; brk_push = 0; branch_cond = 3'd0;
        do_reset();
        total++; if (status_out !== 8'h24) begin bad++; $display("FAIL reset_status got=%h exp=24", status_out); end
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq_req); end
        total++; if (nmi_req !== 1'b0) begin bad++; $display("FAIL reset_nmi got=%b exp=0", nmi_req); end
        irq_n = 0; #1;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_irq_masked got=%b exp=0", irq_req); end
        irq_n = 1;
        $display("test_reset: status=%h", status_out);
    endtask

    task automatic test_plp();
        plp_load = 1; data_in = 8'hFF;
        step(); idle();
        total++; if (status_out !== 8'hEF) begin bad++; $display("FAIL plp_ff_brk0 got=%h exp=EF", status_out); end
        brk_push = 1; #1;
        total++; if (status_out !== 8'hFF) begin bad++; $display("FAIL plp_ff_brk1 got=%h exp=FF", status_out); end
        brk_push = 0;
        $display("test_plp: status=%h", status_out);
    endtask

    task automatic test_priority();
        // plp beats flag_op and ALU carry
        plp_load = 1; data_in = 8'h00; flag_op = 3'd2; load_c = 1; alu_carry = 1;
        step(); idle();
        total++; if (status_out !== 8'h20) begin bad++; $display("FAIL prio_plp got=%h exp=20", status_out); end
        // flag_op (SEC) beats bit_op
        flag_op = 3'd2; bit_op = 1; data_in = 8'hC0; alu_zero = 1;
        step(); idle();
        total++; if (status_out !== 8'h21) begin bad++; $display("FAIL prio_flagop got=%h exp=21", status_out); end
        // bit_op beats load_nz / load_c
        bit_op = 1; data_in = 8'h40; alu_zero = 1; load_nz = 1; alu_sign = 1; load_c = 1; alu_carry = 0;
        step(); idle();
        total++; if (status_out !== 8'h63) begin bad++; $display("FAIL prio_bitop got=%h exp=63", status_out); end
        $display("test_priority: status=%h", status_out);
    endtask

    task automatic test_flag_op();
        logic [2:0] ops [8];
        logic [7:0] exps [8];
        ops  = '{3'd6, 3'd4, 3'd7, 3'd1, 3'd5, 3'd3, 3'd2, 3'd0};
        exps = '{8'h6B, 8'h6F, 8'h2F, 8'h2E, 8'h26, 8'h22, 8'h23, 8'h23};
        for (int k = 0; k < 8; k++) begin
            flag_op = ops[k];
            step(); idle();
            total++;
            if (status_out !== exps[k]) begin
                bad++; $display("FAIL flag_op_%0d got=%h exp=%h", ops[k], status_out, exps[k]);
            end
            $display("test_flag_op: op=%0d status=%h", ops[k], status_out);
        end
    endtask

    task automatic test_alu();
        load_nz = 1; alu_sign = 1; alu_zero = 0;
        step(); idle();
        total++; if (status_out !== 8'hA1) begin bad++; $display("FAIL alu_nz got=%h exp=A1", status_out); end
        load_v = 1; alu_overflow = 1; load_c = 1; alu_carry = 0;
        step(); idle();
        total++; if (status_out !== 8'hE0) begin bad++; $display("FAIL alu_vc got=%h exp=E0", status_out); end
        load_nz = 1; alu_sign = 0; alu_zero = 1; load_c = 1; alu_carry = 1;
        step(); idle();
        total++; if (status_out !== 8'h63) begin bad++; $display("FAIL alu_nzc got=%h exp=63", status_out); end
        alu_sign = 1; alu_zero = 0; alu_carry = 0; alu_overflow = 0;
        step(); idle();
        total++; if (status_out !== 8'h63) begin bad++; $display("FAIL alu_noenable got=%h exp=63", status_out); end
        $display("test_alu: status=%h", status_out);
    endtask

    task automatic test_bit_op();
        logic [7:0] exp_br;
        plp_load = 1; data_in = 8'h01;
        step(); idle();
        bit_op = 1; data_in = 8'hC0; alu_zero = 1;
        step(); idle();
        total++; if (status_out !== 8'hE3) begin bad++; $display("FAIL bit_op got=%h exp=E3", status_out); end
        exp_br = 8'b1010_1010;
        for (int k = 0; k < 8; k++) begin
            branch_cond = 3'(k); #1;
            total++;
            if (branch_taken !== exp_br[k]) begin
                bad++; $display("FAIL branch_set_%0d got=%b exp=%b", k, branch_taken, exp_br[k]);
            end
        end
        plp_load = 1; data_in = 8'h00;
        step(); idle();
        exp_br = 8'b0101_0101;
        for (int k = 0; k < 8; k++) begin
            branch_cond = 3'(k); #1;
            total++;
            if (branch_taken !== exp_br[k]) begin
                bad++; $display("FAIL branch_clr_%0d got=%b exp=%b", k, branch_taken, exp_br[k]);
            end
        end
        $display("test_bit_op: status=%h", status_out);
    endtask

    task automatic test_irq();
        do_reset();
        irq_n = 0; flag_op = 3'd3;
        step(); idle();
        total++; if (status_out !== 8'h20) begin bad++; $display("FAIL irq_cli_flag got=%h exp=20", status_out); end
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL irq_before_sample got=%b exp=0", irq_req); end
        ready = 0; intr_sample = 1;
        step(); idle();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL irq_sample_stalled got=%b exp=0", irq_req); end
        intr_sample = 1;
        step(); idle();
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL irq_after_sample got=%b exp=1", irq_req); end
        irq_n = 1; #1;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL irq_level got=%b exp=0", irq_req); end
        irq_n = 0; flag_op = 3'd4; intr_sample = 1;
        step(); idle();
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL irq_sei_same got=%b exp=1", irq_req); end
        intr_sample = 1;
        step(); idle();
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL irq_sei_late got=%b exp=0", irq_req); end
        irq_n = 1;
        $display("test_irq: irq_req=%b", irq_req);
    endtask

    task automatic test_nmi();
        nmi_n = 0;
        step();
        total++; if (nmi_req !== 1'b1) begin bad++; $display("FAIL nmi_edge got=%b exp=1", nmi_req); end
        step();
        total++; if (nmi_req !== 1'b1) begin bad++; $display("FAIL nmi_hold got=%b exp=1", nmi_req); end
        nmi_ack = 1;
        step(); nmi_ack = 0;
        total++; if (nmi_req !== 1'b0) begin bad++; $display("FAIL nmi_ack got=%b exp=0", nmi_req); end
        for (int k = 0; k < 3; k++) step();
        total++; if (nmi_req !== 1'b0) begin bad++; $display("FAIL nmi_low_noretrig got=%b exp=0", nmi_req); end
        nmi_n = 1;
        step();
        total++; if (nmi_req !== 1'b0) begin bad++; $display("FAIL nmi_rise got=%b exp=0", nmi_req); end
        nmi_n = 0;
        step();
        total++; if (nmi_req !== 1'b1) begin bad++; $display("FAIL nmi_second_edge got=%b exp=1", nmi_req); end
        nmi_n = 1;
        step();
        nmi_n = 0; nmi_ack = 1;
        step(); nmi_ack = 0;
        total++; if (nmi_req !== 1'b1) begin bad++; $display("FAIL nmi_edge_vs_ack got=%b exp=1", nmi_req); end
        nmi_ack = 1;
        step(); nmi_ack = 0;
        total++; if (nmi_req !== 1'b0) begin bad++; $display("FAIL nmi_final_ack got=%b exp=0", nmi_req); end
        nmi_n = 1;
        step();
        $display("test_nmi: nmi_req=%b", nmi_req);
    endtask

    task automatic test_ready();
        plp_load = 1; data_in = 8'h00;
        step(); idle();
        ready = 0; load_nz = 1; alu_sign = 1; alu_zero = 1;
        step(); idle();
        total++; if (status_out !== 8'h20) begin bad++; $display("FAIL ready_load_nz got=%h exp=20", status_out); end
        ready = 0; plp_load = 1; data_in = 8'hFF;
        step(); idle();
        total++; if (status_out !== 8'h20) begin bad++; $display("FAIL ready_plp got=%h exp=20", status_out); end
        ready = 0; nmi_n = 0;
        step();
        total++; if (nmi_req !== 1'b1) begin bad++; $display("FAIL ready_nmi_edge got=%b exp=1", nmi_req); end
        ready = 0; nmi_ack = 1;
        step();
        total++; if (nmi_req !== 1'b1) begin bad++; $display("FAIL ready_nmi_ack_stalled got=%b exp=1", nmi_req); end
        ready = 1;
        step(); idle();
        total++; if (nmi_req !== 1'b0) begin bad++; $display("FAIL ready_nmi_ack got=%b exp=0", nmi_req); end
        nmi_n = 1;
        ready = 0; reset = 1; load_nz = 1; alu_sign = 1;
        step(); idle();
        total++; if (status_out !== 8'h24) begin bad++; $display("FAIL reset_over_ready got=%h exp=24", status_out); end
        $display("test_ready: status=%h nmi_req=%b", status_out, nmi_req);
    endtask

    initial begin
        idle();
        test_reset();
        test_plp();
        test_priority();
        test_flag_op();
        test_alu();
        test_bit_op();
        test_irq();
        test_nmi();
        test_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
